// File: rtl/maxpool_ctrl.sv
// Sequencer for the 2x2/stride-2 maxpool unit: walks an INT8 plane in raster order, fetches each
// window through a 1-cycle-latency read port, hands it to the pool unit and writes the result back.
module maxpool_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [DIM_W-1:0]  cfg_width,
  input  logic        [DIM_W-1:0]  cfg_height,
  input  logic        [ADDR_W-1:0] cfg_in_base,
  input  logic        [ADDR_W-1:0] cfg_out_base,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [7:0]        rd_data,
  output logic                     mp_valid,
  output logic signed [7:0]        mp_a,
  output logic signed [7:0]        mp_b,
  output logic signed [7:0]        mp_c,
  output logic signed [7:0]        mp_d,
  input  logic signed [7:0]        mp_max,
  input  logic                     mp_done,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [7:0]        wr_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, CAP, POOL, WR, DONE} state_t;

  state_t              state, state_nx;
  logic [DIM_W-1:0]    ox, oy;
  logic [DIM_W-1:0]    ow_q, oh_q;
  logic [ADDR_W-1:0]   w_q;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   out_addr;
  logic [ADDR_W-1:0]   col_off;
  logic                accept, last_col, last_win, wr_fire;

  assign accept   = (state == IDLE) && start;
  assign last_col = (ox == ow_q - DIM_W'(1));
  assign last_win = last_col && (oy == oh_q - DIM_W'(1));
  assign wr_fire  = (state == WR) && mp_done;
  assign col_off  = ADDR_W'({ox, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        // A plane narrower or shorter than 2 has no complete window
        if (cfg_width[DIM_W-1:1] == '0 || cfg_height[DIM_W-1:1] == '0) state_nx = DONE;
        else                                                           state_nx = RD0;
      end
      RD0:  state_nx = RD1;
      RD1:  state_nx = RD2;
      RD2:  state_nx = RD3;
      RD3:  state_nx = CAP;
      CAP:  state_nx = POOL;
      POOL: state_nx = WR;
      WR:   if (mp_done) state_nx = last_win ? DONE : RD0;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window counters and captured pixels (visible on mp_a..mp_d, so they reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox   <= '0;
      oy   <= '0;
      mp_a <= '0;
      mp_b <= '0;
      mp_c <= '0;
      mp_d <= '0;
    end else begin
      if (accept) begin
        ox <= '0;
        oy <= '0;
      end else if (wr_fire && !last_win) begin
        if (last_col) begin
          ox <= '0;
          oy <= oy + DIM_W'(1);
        end else begin
          ox <= ox + DIM_W'(1);
        end
      end
      if (state == RD1) mp_a <= rd_data;
      if (state == RD2) mp_b <= rd_data;
      if (state == RD3) mp_c <= rd_data;
      if (state == CAP) mp_d <= rd_data;
    end
  end

  // Latched config and address accumulators; row_base steps two input rows per output row
  always_ff @(posedge clk) begin
    if (accept) begin
      w_q      <= ADDR_W'(cfg_width);
      ow_q     <= cfg_width >> 1;
      oh_q     <= cfg_height >> 1;
      row_base <= cfg_in_base;
      out_addr <= cfg_out_base;
    end else if (wr_fire) begin
      out_addr <= out_addr + ADDR_W'(1);
      if (last_col) row_base <= row_base + (w_q << 1);
    end
  end

  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = '0;
    mp_valid = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    done     = 1'b0;
    case (state)
      RD0:  begin rd_en = 1'b1; rd_addr = row_base + col_off; end
      RD1:  begin rd_en = 1'b1; rd_addr = row_base + col_off + ADDR_W'(1); end
      RD2:  begin rd_en = 1'b1; rd_addr = row_base + w_q + col_off; end
      RD3:  begin rd_en = 1'b1; rd_addr = row_base + w_q + col_off + ADDR_W'(1); end
      POOL: mp_valid = 1'b1;
      WR:   if (mp_done) begin
        wr_en   = 1'b1;
        wr_addr = out_addr;
        wr_data = mp_max;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);

endmodule
